// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Function : Scoreboard-based load-use stall, bubble and EX operand-forwarding
//            control. Define PIPE_ZERO_REG_EN to make register id 0 a
//            hardwired zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int REG_ID_W   = 4,
  parameter int LOAD_STAGE = 3,
  parameter int FSEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                id_valid,
  input  logic [REG_ID_W-1:0] id_src1,
  input  logic [REG_ID_W-1:0] id_src2,
  input  logic                id_src1_en,
  input  logic                id_src2_en,
  input  logic [REG_ID_W-1:0] id_dst,
  input  logic                id_wr,
  input  logic                id_load,
  input  logic                flush,
  output logic                pc_we,
  output logic                ifid_we,
  output logic                bubble,
  output logic [FSEL_W-1:0]   ex_fwd1,
  output logic [FSEL_W-1:0]   ex_fwd2,
  output logic [15:0]         stall_cnt
);

  // Per-stage scoreboard; only stage 1 needs its source ids for forwarding.
  logic                r_v    [1:DEPTH];
  logic                r_wr   [1:DEPTH];
  logic                r_load [1:DEPTH];
  logic [REG_ID_W-1:0] r_dst  [1:DEPTH];
  logic [REG_ID_W-1:0] r_src1;
  logic [REG_ID_W-1:0] r_src2;
  logic                r_src1_en;
  logic                r_src2_en;
  logic [15:0]         r_stall_cnt;

  logic                w_id_src1_zero;
  logic                w_id_src2_zero;
  logic                w_id_dst_zero;
  logic                w_ex_src1_zero;
  logic                w_ex_src2_zero;
  logic                w_haz1;
  logic                w_haz2;
  logic                w_stall;
  logic [FSEL_W-1:0]   w_fwd1;
  logic [FSEL_W-1:0]   w_fwd2;

`ifdef PIPE_ZERO_REG_EN
  assign w_id_src1_zero = (id_src1 == '0);
  assign w_id_src2_zero = (id_src2 == '0);
  assign w_id_dst_zero  = (id_dst == '0);
  assign w_ex_src1_zero = (r_src1 == '0);
  assign w_ex_src2_zero = (r_src2 == '0);
`else
  assign w_id_src1_zero = 1'b0;
  assign w_id_src2_zero = 1'b0;
  assign w_id_dst_zero  = 1'b0;
  assign w_ex_src1_zero = 1'b0;
  assign w_ex_src2_zero = 1'b0;
`endif

  // Walk oldest to youngest so the youngest matching writer decides.
  always_comb begin
    w_haz1 = 1'b0;
    w_haz2 = 1'b0;
    for (int s = DEPTH; s >= 1; s--) begin
      if (r_v[s] && r_wr[s] && (r_dst[s] == id_src1))
        w_haz1 = r_load[s] && (s + 1 < LOAD_STAGE);
      if (r_v[s] && r_wr[s] && (r_dst[s] == id_src2))
        w_haz2 = r_load[s] && (s + 1 < LOAD_STAGE);
    end
    w_stall = id_valid && !flush &&
              ((id_src1_en && !w_id_src1_zero && w_haz1) ||
               (id_src2_en && !w_id_src2_zero && w_haz2));
  end

  always_comb begin
    w_fwd1 = '0;
    w_fwd2 = '0;
    for (int s = DEPTH; s >= 2; s--) begin
      if (r_v[s] && r_wr[s] && (r_dst[s] == r_src1))
        w_fwd1 = (r_load[s] && (s < LOAD_STAGE)) ? '0 : FSEL_W'(s);
      if (r_v[s] && r_wr[s] && (r_dst[s] == r_src2))
        w_fwd2 = (r_load[s] && (s < LOAD_STAGE)) ? '0 : FSEL_W'(s);
    end
    if (!r_v[1] || !r_src1_en || w_ex_src1_zero)
      w_fwd1 = '0;
    if (!r_v[1] || !r_src2_en || w_ex_src2_zero)
      w_fwd2 = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 1; s <= DEPTH; s++) begin
        r_v[s]    <= 1'b0;
        r_wr[s]   <= 1'b0;
        r_load[s] <= 1'b0;
        r_dst[s]  <= '0;
      end
      r_src1      <= '0;
      r_src2      <= '0;
      r_src1_en   <= 1'b0;
      r_src2_en   <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      for (int s = DEPTH; s >= 2; s--) begin
        r_v[s]    <= r_v[s-1];
        r_wr[s]   <= r_wr[s-1];
        r_load[s] <= r_load[s-1];
        r_dst[s]  <= r_dst[s-1];
      end
      r_v[1]    <= id_valid && !w_stall && !flush;
      r_wr[1]   <= id_wr && !w_id_dst_zero;
      r_load[1] <= id_load;
      r_dst[1]  <= id_dst;
      r_src1    <= id_src1;
      r_src2    <= id_src2;
      r_src1_en <= id_src1_en;
      r_src2_en <= id_src2_en;
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign pc_we     = !w_stall;
  assign ifid_we   = !w_stall;
  assign bubble    = w_stall || flush;
  assign ex_fwd1   = w_fwd1;
  assign ex_fwd2   = w_fwd2;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Function : Self-checking bench for pipe_hazard_ctrl against an instruction-
//            queue reference model; honours PIPE_ZERO_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int DEPTH      = 3;
  localparam int REG_ID_W   = 4;
  localparam int LOAD_STAGE = 3;
  localparam int FSEL_W     = $clog2(DEPTH + 1);
`ifdef PIPE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RST;
  logic                id_valid;
  logic [REG_ID_W-1:0] id_src1;
  logic [REG_ID_W-1:0] id_src2;
  logic                id_src1_en;
  logic                id_src2_en;
  logic [REG_ID_W-1:0] id_dst;
  logic                id_wr;
  logic                id_load;
  logic                flush;
  logic                pc_we;
  logic                ifid_we;
  logic                bubble;
  logic [FSEL_W-1:0]   ex_fwd1;
  logic [FSEL_W-1:0]   ex_fwd2;
  logic [15:0]         stall_cnt;

  pipe_hazard_ctrl #(
    .DEPTH(DEPTH), .REG_ID_W(REG_ID_W), .LOAD_STAGE(LOAD_STAGE)
  ) dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load), .flush(flush),
    .pc_we(pc_we), .ifid_we(ifid_we), .bubble(bubble),
    .ex_fwd1(ex_fwd1), .ex_fwd2(ex_fwd2), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int dst;
    int s1;
    bit e1;
    int s2;
    bit e2;
  } ins_t;

  // pipe_q[0] is the instruction in stage 1 (EX), pipe_q[k] is stage k+1.
  ins_t pipe_q[$];
  int   m_cnt;
  int   n_tests;
  int   n_fail;

  function automatic ins_t ent(int s);
    ins_t e;
    e = '{default: 0};
    if (s - 1 < pipe_q.size()) e = pipe_q[s-1];
    return e;
  endfunction

  function automatic bit src_hazard(int src, bit en);
    ins_t e;
    if (!en || (ZERO_EN && src == 0)) return 1'b0;
    for (int s = 1; s <= DEPTH; s++) begin
      e = ent(s);
      if (e.v && e.wr && e.dst == src) return e.ld && (s + 1 < LOAD_STAGE);
    end
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    if (flush || !id_valid) return 1'b0;
    return src_hazard(int'(id_src1), id_src1_en) || src_hazard(int'(id_src2), id_src2_en);
  endfunction

  function automatic int model_fwd(bit second);
    ins_t e1, e;
    int   src;
    bit   en;
    e1  = ent(1);
    src = second ? e1.s2 : e1.s1;
    en  = second ? e1.e2 : e1.e1;
    if (!e1.v || !en || (ZERO_EN && src == 0)) return 0;
    for (int s = 2; s <= DEPTH; s++) begin
      e = ent(s);
      if (e.v && e.wr && e.dst == src) return (e.ld && s < LOAD_STAGE) ? 0 : s;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit st;
    st = model_stall();
    chk("pc_we", pc_we, !st);
    chk("ifid_we", ifid_we, !st);
    chk("bubble", bubble, st || flush);
    chk("ex_fwd1", ex_fwd1, model_fwd(1'b0));
    chk("ex_fwd2", ex_fwd2, model_fwd(1'b1));
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic drive(input int v, input int s1, input int e1, input int s2, input int e2,
                       input int dst, input int wr, input int ld, input int fl);
    id_valid   = v[0];
    id_src1    = s1[REG_ID_W-1:0];
    id_src1_en = e1[0];
    id_src2    = s2[REG_ID_W-1:0];
    id_src2_en = e2[0];
    id_dst     = dst[REG_ID_W-1:0];
    id_wr      = wr[0];
    id_load    = ld[0];
    flush      = fl[0];
    #2;
    compare();
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit   st;
    ins_t r;
    st = model_stall();
    @(posedge CLK);
    r.v   = id_valid && !st && !flush;
    r.wr  = id_wr && !(ZERO_EN && id_dst == '0);
    r.ld  = id_load;
    r.dst = int'(id_dst);
    r.s1  = int'(id_src1);
    r.e1  = id_src1_en;
    r.s2  = int'(id_src2);
    r.e2  = id_src2_en;
    pipe_q.push_front(r);
    if (pipe_q.size() > DEPTH) void'(pipe_q.pop_back());
    if (st && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic model_reset();
    pipe_q.delete();
    m_cnt = 0;
  endtask

  initial begin
    bit hold;
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    RST = 1'b1;
    id_valid = 0; id_src1 = '0; id_src2 = '0; id_src1_en = 0; id_src2_en = 0;
    id_dst = '0; id_wr = 0; id_load = 0; flush = 0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    nop();
    chk("rst_pc_we", pc_we, 1);
    chk("rst_bubble", bubble, 0);
    chk("rst_fwd1", ex_fwd1, 0);
    chk("rst_cnt", stall_cnt, 0);
    tick();

    // ALU chain, back-to-back then with one gap
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    drive(1, 1, 1, 0, 0, 2, 1, 0, 0);
    chk("alu_nostall", pc_we, 1);
    tick();
    nop(); chk("alu_fwd2", ex_fwd1, 2); tick();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0); tick();
    drive(1, 1, 1, 0, 0, 2, 1, 0, 0); tick();
    nop(); chk("alu_fwd3", ex_fwd1, 3); tick();

    // Load-use: LW R3 ; ADD R4,R3
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0); tick();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
    chk("lu_pc_we", pc_we, 0);
    chk("lu_ifid_we", ifid_we, 0);
    chk("lu_bubble", bubble, 1);
    tick();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
    chk("lu_release", pc_we, 1);
    chk("lu_cnt", stall_cnt, 1);
    tick();
    nop(); chk("lu_fwd", ex_fwd1, 3); tick();

    // Shadowing: two writers of R5, consumer sees the younger one
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
    drive(1, 0, 0, 5, 1, 6, 1, 0, 0); tick();
    nop(); chk("shadow_fwd", ex_fwd2, 2); tick();

    // Flush coinciding with a load-use stall
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0); tick();
    drive(1, 6, 1, 8, 1, 7, 1, 0, 1);
    chk("flush_bubble", bubble, 1);
    chk("flush_pc_we", pc_we, 1);
    tick();
    nop();
    chk("flush_cnt", stall_cnt, 1);
    chk("flush_kill", ex_fwd2, 0);
    tick();

    // Register 0 as load target
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0);
    chk("zero_stall", pc_we, ZERO_EN ? 1 : 0);
    tick();
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0); tick();
    nop(); chk("zero_fwd", ex_fwd1, ZERO_EN ? 0 : 3); tick();

    // Asynchronous reset in the middle of a stall
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0); tick();
    drive(1, 9, 1, 0, 0, 10, 1, 0, 0);
    chk("rst_pre_stall", bubble, 1);
    #1 RST = 1'b1;
    #1;
    chk("rst_mid_pc_we", pc_we, 1);
    chk("rst_mid_ifid_we", ifid_we, 1);
    chk("rst_mid_bubble", bubble, 0);
    chk("rst_mid_fwd1", ex_fwd1, 0);
    chk("rst_mid_fwd2", ex_fwd2, 0);
    chk("rst_mid_cnt", stall_cnt, 0);
    #1 RST = 1'b0;
    model_reset();
    tick();

    // Randomized traffic; a stalled ID instruction is held until it issues
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit st;
      if (hold) begin
        drive(id_valid, id_src1, id_src1_en, id_src2, id_src2_en, id_dst, id_wr, id_load,
              ($urandom_range(0, 15) == 0));
      end else begin
        int v;
        v = ($urandom_range(0, 7) != 0);
        drive(v, $urandom_range(0, 3), v & ($urandom_range(0, 3) != 0),
              $urandom_range(0, 3), v & ($urandom_range(0, 3) != 0),
              $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      end
      st = model_stall();
      if ($urandom_range(0, 499) == 0) begin
        #1 RST = 1'b1;
        #1 model_reset();
        compare();
        #1 RST = 1'b0;
        st = 1'b0;
      end
      hold = st;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
